// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        PC_HOLD     = 2'd0,
        PC_INC      = 2'd1,
        PC_BRANCH   = 2'd2,
        PC_REDIRECT = 2'd3
    } pc_sel_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Request/acknowledge bus between the fetch unit and instruction memory.
interface if_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);

endinterface

// File: rtl/if_fetch_unit_next_pc.sv
// Next-PC selector: sequential, branch target, deferred redirect, or hold.
module if_next_pc
    import if_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] branch_target,
    input  logic [31:0] redirect_pc,
    input  pc_sel_e     sel,
    output logic [31:0] next_pc
);

    always_comb begin
        case (sel)
            PC_INC:      next_pc = pc + 32'd4;
            PC_BRANCH:   next_pc = branch_target;
            PC_REDIRECT: next_pc = redirect_pc;
            default:     next_pc = pc;
        endcase
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks req/ack to instruction memory.
// Optional perf counters are built only when IF_PERF_COUNTERS_EN is defined.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_shouldStall,
    input  logic                   id_branchTaken,
    input  logic [31:0]            id_branchTarget,
    if_fetch_unit_if.master        imem,
    output logic [31:0]            if_pc,
    output logic [31:0]            if_pc_4,
    output logic [31:0]            if_instruction,
    output logic [31:0]            if_fetchCount,
    output logic [31:0]            if_waitCycles
);

    state_e      state, state_next;
    pc_sel_e     pc_sel;
    logic [31:0] pc, next_pc, hold_buf, redirect_pc, instr;
    logic        redirect, load_hold, load_redirect;

    // A redirect is only honoured when ID is not stalling.
    assign redirect = id_branchTaken && !id_shouldStall;

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_next    = state;
        pc_sel        = PC_HOLD;
        instr         = NOP_INSTR;
        load_hold     = 1'b0;
        load_redirect = 1'b0;
        case (state)
            FETCH: begin
                if (imem.imem_ack) begin
                    if (id_shouldStall) begin
                        load_hold  = 1'b1;
                        state_next = HOLD;
                    end else if (redirect) begin
                        pc_sel = PC_BRANCH;
                    end else begin
                        instr  = imem.imem_rdata;
                        pc_sel = PC_INC;
                    end
                end else if (redirect) begin
                    load_redirect = 1'b1;
                    state_next    = DRAIN;
                end
            end
            HOLD: begin
                if (!id_shouldStall) begin
                    state_next = FETCH;
                    if (redirect) begin
                        pc_sel = PC_BRANCH;
                    end else begin
                        instr  = hold_buf;
                        pc_sel = PC_INC;
                    end
                end
            end
            DRAIN: begin
                load_redirect = redirect;
                if (imem.imem_ack) begin
                    state_next = FETCH;
                    pc_sel     = redirect ? PC_BRANCH : PC_REDIRECT;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    if_next_pc u_next_pc (
        .pc            (pc),
        .branch_target (id_branchTarget),
        .redirect_pc   (redirect_pc),
        .sel           (pc_sel),
        .next_pc       (next_pc)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            hold_buf    <= NOP_INSTR;
            redirect_pc <= 32'h0;
        end else begin
            state <= state_next;
            pc    <= next_pc;
            if (load_hold)     hold_buf    <= imem.imem_rdata;
            if (load_redirect) redirect_pc <= id_branchTarget;
        end
    end

    // Address is the held PC, so it cannot move while a request is outstanding.
    assign imem.imem_req  = !rst && (state != HOLD);
    assign imem.imem_addr = pc;
    assign if_pc          = pc;
    assign if_pc_4        = rst ? RESET_PC + 32'd4 : pc + 32'd4;
    assign if_instruction = rst ? NOP_INSTR : instr;

`ifdef IF_PERF_COUNTERS_EN
    logic fetch_pulse, wait_pulse;

    assign fetch_pulse = (pc_sel == PC_INC);
    assign wait_pulse  = imem.imem_req && !imem.imem_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            if_fetchCount <= 32'h0;
            if_waitCycles <= 32'h0;
        end else begin
            if (fetch_pulse && if_fetchCount != 32'hFFFF_FFFF) if_fetchCount <= if_fetchCount + 32'd1;
            if (wait_pulse  && if_waitCycles != 32'hFFFF_FFFF) if_waitCycles <= if_waitCycles + 32'd1;
        end
    end
`else
    assign if_fetchCount = 32'h0;
    assign if_waitCycles = 32'h0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit against a behavioural fetch model.
`timescale 1ns/1ps
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, id_shouldStall, id_branchTaken;
    logic [31:0] id_branchTarget;
    logic [31:0] if_pc, if_pc_4, if_instruction, if_fetchCount, if_waitCycles;

    if_fetch_unit_if imem ();

    if_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_shouldStall  (id_shouldStall),
        .id_branchTaken  (id_branchTaken),
        .id_branchTarget (id_branchTarget),
        .imem            (imem),
        .if_pc           (if_pc),
        .if_pc_4         (if_pc_4),
        .if_instruction  (if_instruction),
        .if_fetchCount   (if_fetchCount),
        .if_waitCycles   (if_waitCycles)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the PC, a parked word (fetched during a stall),
    // and a pending squash of the in-flight fetch with its eventual target.
    logic [31:0] m_pc = RST_PC;
    logic [31:0] m_buf = 32'h0;
    logic [31:0] m_tgt = 32'h0;
    logic [31:0] m_fcnt = 32'h0;
    logic [31:0] m_wcnt = 32'h0;
    bit          m_buf_valid = 1'b0;
    bit          m_squash = 1'b0;
    int          mem_wait = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit r, input bit s, input bit b, input logic [31:0] t,
                         input bit a, input logic [31:0] d);
        bit          redir, delivered, e_req;
        logic [31:0] e_instr, e_pc4, n_pc;
        rst = r; id_shouldStall = s; id_branchTaken = b; id_branchTarget = t;
        imem.imem_ack = a; imem.imem_rdata = d;
        #2;
        redir     = b && !s;
        e_req     = !r && !m_buf_valid;
        e_instr   = 32'h0;
        e_pc4     = r ? RST_PC + 32'd4 : m_pc + 32'd4;
        delivered = 1'b0;
        n_pc      = m_pc;
        check("imem_req", {31'h0, imem.imem_req}, {31'h0, e_req});
        check("if_pc_4", if_pc_4, e_pc4);
        if (!r) begin
            if (m_buf_valid) begin
                if (!s) begin
                    if (redir) n_pc = t;
                    else begin e_instr = m_buf; delivered = 1'b1; n_pc = m_pc + 32'd4; end
                    m_buf_valid = 1'b0;
                end
            end else if (m_squash) begin
                if (redir) m_tgt = t;
                if (a) begin n_pc = m_tgt; m_squash = 1'b0; end
            end else if (a) begin
                if (s) begin m_buf = d; m_buf_valid = 1'b1; end
                else if (redir) n_pc = t;
                else begin e_instr = d; delivered = 1'b1; n_pc = m_pc + 32'd4; end
            end else if (redir) begin
                m_squash = 1'b1; m_tgt = t;
            end
            if (e_req) check("imem_addr", imem.imem_addr, m_pc);
            check("if_pc", if_pc, m_pc);
            check("if_fetchCount", if_fetchCount, m_fcnt);
            check("if_waitCycles", if_waitCycles, m_wcnt);
        end
        check("if_instruction", if_instruction, e_instr);
        @(posedge clk);
        #1;
        if (r) begin
            m_pc = RST_PC; m_buf_valid = 1'b0; m_squash = 1'b0; m_tgt = 32'h0;
            m_fcnt = 32'h0; m_wcnt = 32'h0; mem_wait = 0;
        end else begin
            m_pc = n_pc;
`ifdef IF_PERF_COUNTERS_EN
            if (delivered && m_fcnt != 32'hFFFF_FFFF) m_fcnt++;
            if (e_req && !a && m_wcnt != 32'hFFFF_FFFF) m_wcnt++;
`endif
        end
    endtask

    // Memory responder: acks a request after `lat` wait cycles; data = addr ^ A5A5_0000.
    task automatic step(input bit s, input bit b, input logic [31:0] t, input int lat);
        bit a = 1'b0;
        if (!m_buf_valid) begin
            if (mem_wait >= lat) begin a = 1'b1; mem_wait = 0; end
            else mem_wait++;
        end
        cycle(1'b0, s, b, t, a, m_pc ^ 32'hA5A5_0000);
    endtask

    logic [31:0] pc0;

    initial begin
        // Reset for two cycles
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("reset_pc", if_pc, RST_PC);

        // Zero-latency streaming
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 32'h0, 0);
        check("stream_pc", if_pc, 32'h0000_0040);

        // Latency: two bubbles per instruction
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'h0, 2);
        check("latency_pc", if_pc, 32'h0000_0050);

        // Stall on ack, held two cycles, then delivered once
        mem_wait = 0;
        pc0 = m_pc;
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h2008_0001);
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check("hold_no_req", {31'h0, imem.imem_req}, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("stall_pc_adv", if_pc, pc0 + 32'd4);

        // Redirect coincident with ack lands at 0x10
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b1, 32'h1111_1111);
        check("coinc_addr", imem.imem_addr, 32'h0000_0010);

        // Redirect while waiting -> drain, late data discarded
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("drain_addr_old", imem.imem_addr, 32'h0000_0010);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        check("drain_new_addr", imem.imem_addr, 32'h0000_0100);

        // Redirect while holding a stalled word
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_0777, 1'b1, 32'hCAFE_0001);
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b0, 32'h0);
        check("hold_redir_addr", imem.imem_addr, 32'h0000_0200);

        // Two redirects during drain: last one wins
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0300, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0400, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hBAD0_BAD0);
        check("last_wins_addr", imem.imem_addr, 32'h0000_0400);

        // PC wrap past 32'hFFFF_FFFC
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 32'h0);
        mem_wait = 0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 0);
        check("wrap_pc", if_pc, 32'h0000_0004);

        // Randomised stalls, redirects and memory latency
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
                 $urandom & 32'hFFFF_FFFC, $urandom_range(0, 3));

        // Settle into a plain fetch, then reset with a request outstanding at 0x40
        for (int i = 0; i < 4; i++)
            if (m_buf_valid || m_squash) step(1'b0, 1'b0, 32'h0, 0);
        mem_wait = 0;
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0040, 1'b1, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("pre_rst_addr", imem.imem_addr, 32'h0000_0040);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("rst_mid_pc", if_pc, RST_PC);
        check("rst_mid_req", {31'h0, imem.imem_req}, 32'h0);
        check("rst_fcnt", if_fetchCount, 32'h0);
        check("rst_wcnt", if_waitCycles, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
